// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI mode-0 byte master (CPOL=0, CPHA=0), MSB first, full duplex.
// Define SPI_MASTER_BURST_EN to chain a new byte onto the done cycle without raising cs.
module spi_master #(
  parameter int HALF_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_data,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_data,
  output logic       sclk,
  output logic       cs,
  output logic       sending,
  output logic       mosi,
  input  logic       miso
);

  localparam int CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t        state;
  logic [7:0]    tx_shift;
  logic [7:0]    rx_shift;
  logic [CW-1:0] div_cnt;
  logic [4:0]    edge_cnt;
  logic          half_end;

  assign half_end = (div_cnt == CW'(HALF_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx_shift <= 8'h00;
      rx_shift <= 8'h00;
      div_cnt  <= '0;
      edge_cnt <= 5'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rx_data  <= 8'h00;
      sclk     <= 1'b0;
      cs       <= 1'b1;
      sending  <= 1'b0;
      mosi     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          div_cnt  <= '0;
          edge_cnt <= 5'd0;
          if (start) begin
            tx_shift <= tx_data;
            mosi     <= tx_data[7];
            cs       <= 1'b0;
            sending  <= 1'b1;
            busy     <= 1'b1;
            state    <= SETUP;
          end
        end

        // First rising edge: the slave already presents its MSB while cs is low.
        SETUP: begin
          if (half_end) begin
            div_cnt  <= '0;
            sclk     <= 1'b1;
            edge_cnt <= 5'd1;
            rx_shift <= {rx_shift[6:0], miso};
            state    <= SHIFT;
          end else begin
            div_cnt <= div_cnt + CW'(1);
          end
        end

        SHIFT: begin
          if (half_end) begin
            div_cnt  <= '0;
            edge_cnt <= edge_cnt + 5'd1;
            if (sclk) begin
              sclk     <= 1'b0;
              tx_shift <= {tx_shift[6:0], 1'b0};
              mosi     <= tx_shift[6];
              if (edge_cnt == 5'd15) begin
                state <= HOLD;
              end
            end else begin
              sclk     <= 1'b1;
              rx_shift <= {rx_shift[6:0], miso};
            end
          end else begin
            div_cnt <= div_cnt + CW'(1);
          end
        end

        HOLD: begin
          if (half_end) begin
            div_cnt  <= '0;
            edge_cnt <= 5'd0;
            rx_data  <= rx_shift;
            done     <= 1'b1;
`ifdef SPI_MASTER_BURST_EN
            // Back-to-back: keep cs low and reload straight into SETUP.
            if (start) begin
              tx_shift <= tx_data;
              mosi     <= tx_data[7];
              state    <= SETUP;
            end else begin
              cs      <= 1'b1;
              sending <= 1'b0;
              busy    <= 1'b0;
              state   <= IDLE;
            end
`else
            cs      <= 1'b1;
            sending <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
`endif
          end else begin
            div_cnt <= div_cnt + CW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - self-checking bench for spi_master with a behavioural SPI slave model.
module tb_spi_master;
  localparam int H0 = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       busy, done, sclk, cs, sending, mosi;
  logic [7:0] rx_data;
  logic       miso = 1'b0;

  logic       start1 = 1'b0;
  logic [7:0] tx1 = 8'h00;
  logic       busy1, done1, sclk1, cs1, sending1, mosi1;
  logic [7:0] rx1;
  logic       miso1 = 1'b0;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  spi_master #(.HALF_DIV(H0)) dut (
    .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .busy(busy), .done(done),
    .rx_data(rx_data), .sclk(sclk), .cs(cs), .sending(sending), .mosi(mosi), .miso(miso)
  );

  spi_master #(.HALF_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .tx_data(tx1), .busy(busy1), .done(done1),
    .rx_data(rx1), .sclk(sclk1), .cs(cs1), .sending(sending1), .mosi(mosi1), .miso(miso1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave: MSB out when cs falls, next bit on each falling sclk, reload after 8 bits.
  logic [7:0] slave_b0 = 8'h00, slave_b1 = 8'h00, slave_cur = 8'h00;
  int         slave_cnt = 0;
  logic       cs_prev = 1'b1, sclk_prev = 1'b0;
  always @(cs or sclk) begin
    if (cs_prev === 1'b1 && cs === 1'b0) begin
      slave_cnt = 0;
      slave_cur = slave_b0;
      miso = slave_cur[7];
    end else if (sclk_prev === 1'b1 && sclk === 1'b0 && cs === 1'b0) begin
      slave_cnt++;
      if (slave_cnt == 8) begin
        slave_cnt = 0;
        slave_cur = slave_b1;
      end
      miso = slave_cur[3'(7 - slave_cnt)];
    end
    cs_prev = cs;
    sclk_prev = sclk;
  end

  logic [31:0] mosi_log = 32'h0;
  int          mosi_n = 0;
  always @(posedge sclk) begin
    mosi_log = {mosi_log[30:0], mosi};
    mosi_n++;
  end

  task automatic run_xfer(input logic [7:0] tx, input logic [7:0] sl, input int restart_at,
                          output int t0, output int done_t, output int done_n, output int cs_low_n,
                          output logic [7:0] rx_got, output logic [7:0] mosi_got, output int n_bits,
                          output int n_edges, output int edge_err, output logic [3:0] first);
    int   base;
    logic prev_s;
    slave_b0 = sl;
    slave_b1 = 8'h00;
    @(negedge clk);
    tx_data = tx;
    start = 1'b1;
    t0 = cyc;
    base = mosi_n;
    @(negedge clk);
    start = 1'b0;
    tx_data = 8'($urandom);
    first = {cs, mosi, busy, sending};
    done_t = -1; done_n = 0; cs_low_n = 0; n_edges = 0; edge_err = 0; rx_got = 8'h00;
    prev_s = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (cs === 1'b0) cs_low_n++;
      if (sclk !== prev_s) begin
        n_edges++;
        if (cyc != t0 + 1 + n_edges * H0) edge_err++;
        prev_s = sclk;
      end
      if (done === 1'b1) begin
        done_n++;
        done_t = cyc;
        rx_got = rx_data;
      end
      if (restart_at > 0 && cyc == t0 + restart_at) begin
        start = 1'b1;
        tx_data = 8'h00;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    mosi_got = mosi_log[7:0];
    n_bits = mosi_n - base;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({cs, sclk, sending, mosi, busy, done, rx_data} !== {6'b100000, 8'h00}) begin
      n_bad++;
      $display("FAIL reset_dut: got %b expected %b", {cs, sclk, sending, mosi, busy, done, rx_data}, {6'b100000, 8'h00});
    end
    n_cmp++;
    if ({cs1, sclk1, sending1, mosi1, busy1, done1, rx1} !== {6'b100000, 8'h00}) begin
      n_bad++;
      $display("FAIL reset_dut1: got %b expected %b", {cs1, sclk1, sending1, mosi1, busy1, done1, rx1}, {6'b100000, 8'h00});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_default();
    int t0, dt, dn, csl, nb, ne, ee;
    logic [7:0] rx, mo;
    logic [3:0] first;
    run_xfer(8'hA5, 8'h3C, 0, t0, dt, dn, csl, rx, mo, nb, ne, ee, first);
    n_cmp++;
    if (first !== 4'b0111) begin
      n_bad++; $display("FAIL default_first_cycle {cs,mosi,busy,sending}: got %b expected 0111", first);
    end
    n_cmp++;
    if (dn !== 1) begin n_bad++; $display("FAIL default_done_count: got %0d expected 1", dn); end
    n_cmp++;
    if (dt !== t0 + 1 + 17 * H0) begin
      n_bad++; $display("FAIL default_done_time: got T0+%0d expected T0+%0d", dt - t0, 1 + 17 * H0);
    end
    n_cmp++;
    if (rx !== 8'h3C) begin n_bad++; $display("FAIL default_rx: got %h expected 3c", rx); end
    n_cmp++;
    if (csl !== 17 * H0) begin n_bad++; $display("FAIL default_cs_low: got %0d expected %0d", csl, 17 * H0); end
    n_cmp++;
    if (mo !== 8'hA5 || nb !== 8) begin
      n_bad++; $display("FAIL default_mosi_bits: got %h (%0d bits) expected a5 (8 bits)", mo, nb);
    end
    n_cmp++;
    if (ne !== 16 || ee !== 0) begin
      n_bad++; $display("FAIL default_sclk_edges: got %0d edges, %0d mistimed expected 16, 0", ne, ee);
    end
    n_cmp++;
    if (rx_data !== 8'h3C || mosi !== 1'b0) begin
      n_bad++; $display("FAIL default_idle_hold: got rx %h mosi %b expected rx 3c mosi 0", rx_data, mosi);
    end
  endtask

  task automatic test_ignore_start();
    int t0, dt, dn, csl, nb, ne, ee;
    logic [7:0] rx, mo, sl;
    logic [3:0] first;
    sl = 8'($urandom);
    run_xfer(8'hC3, sl, 10, t0, dt, dn, csl, rx, mo, nb, ne, ee, first);
    n_cmp++;
    if (dn !== 1 || dt !== t0 + 1 + 17 * H0) begin
      n_bad++; $display("FAIL ignore_done: got %0d pulses at T0+%0d expected 1 at T0+%0d", dn, dt - t0, 1 + 17 * H0);
    end
    n_cmp++;
    if (mo !== 8'hC3 || rx !== sl) begin
      n_bad++; $display("FAIL ignore_data: got mosi %h rx %h expected mosi c3 rx %h", mo, rx, sl);
    end
  endtask

  task automatic test_random();
    int t0, dt, dn, csl, nb, ne, ee;
    logic [7:0] rx, mo, tx, sl;
    logic [3:0] first;
    for (int k = 0; k < 4; k++) begin
      tx = 8'($urandom);
      sl = 8'($urandom);
      run_xfer(tx, sl, 0, t0, dt, dn, csl, rx, mo, nb, ne, ee, first);
      n_cmp++;
      if (mo !== tx || rx !== sl || nb !== 8) begin
        n_bad++; $display("FAIL random_%0d_data: got mosi %h rx %h expected mosi %h rx %h", k, mo, rx, tx, sl);
      end
      n_cmp++;
      if (dn !== 1 || dt !== t0 + 1 + 17 * H0 || csl !== 17 * H0) begin
        n_bad++; $display("FAIL random_%0d_timing: got done %0d at T0+%0d cs_low %0d expected 1 at T0+%0d cs_low %0d",
                          k, dn, dt - t0, csl, 1 + 17 * H0, 17 * H0);
      end
    end
  endtask

  task automatic test_half_div1();
    int t0, ne, ee, dn, dt;
    logic prev_s;
    logic first_mosi;
    @(negedge clk);
    tx1 = 8'hFF;
    start1 = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start1 = 1'b0;
    first_mosi = mosi1;
    ne = 0; ee = 0; dn = 0; dt = -1; prev_s = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (sclk1 !== prev_s) begin
        ne++;
        if (cyc != t0 + 1 + ne) ee++;
        prev_s = sclk1;
      end
      if (done1 === 1'b1) begin dn++; dt = cyc; end
      @(negedge clk);
    end
    n_cmp++;
    if (ne !== 16 || ee !== 0 || first_mosi !== 1'b1) begin
      n_bad++; $display("FAIL div1_edges: got %0d edges %0d mistimed mosi0 %b expected 16 0 1", ne, ee, first_mosi);
    end
    n_cmp++;
    if (dn !== 1 || dt !== t0 + 18) begin
      n_bad++; $display("FAIL div1_done: got %0d at T0+%0d expected 1 at T0+18", dn, dt - t0);
    end
    n_cmp++;
    if (rx1 !== 8'h00) begin n_bad++; $display("FAIL div1_rx: got %h expected 00", rx1); end
  endtask

  task automatic test_reset_mid();
    int   ne, dn;
    logic prev_s, reached;
    slave_b0 = 8'($urandom);
    @(negedge clk);
    tx_data = 8'($urandom);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ne = 0; prev_s = 1'b0; reached = 1'b0;
    for (int i = 0; i < 100 && !reached; i++) begin
      if (sclk !== prev_s) begin ne++; prev_s = sclk; end
      if (ne == 7) reached = 1'b1;
      else @(negedge clk);
    end
    n_cmp++;
    if (reached !== 1'b1) begin n_bad++; $display("FAIL rstmid_edge7_reached: got %0d edges expected 7", ne); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({cs, sclk, busy, sending, mosi, done} !== 6'b100000) begin
      n_bad++; $display("FAIL rstmid_outputs: got %b expected 100000", {cs, sclk, busy, sending, mosi, done});
    end
    rst = 1'b0;
    dn = 0;
    for (int i = 0; i < 100; i++) begin
      if (done === 1'b1) dn++;
      @(negedge clk);
    end
    n_cmp++;
    if (dn !== 0 || rx_data !== 8'h00) begin
      n_bad++; $display("FAIL rstmid_no_done: got %0d pulses rx %h expected 0 pulses rx 00", dn, rx_data);
    end
  endtask

  task automatic test_back_to_back();
    int t0, nd, cs_hi, base, exp_gap, exp_hi;
    int d[2];
    logic [7:0] r[2];
    logic [7:0] s0, s1;
    logic drop;
`ifdef SPI_MASTER_BURST_EN
    exp_gap = 17 * H0;
    exp_hi = 0;
`else
    exp_gap = 17 * H0 + 1;
    exp_hi = 1;
`endif
    s0 = 8'($urandom);
    s1 = 8'($urandom);
    slave_b0 = s0;
    slave_b1 = s1;
    @(negedge clk);
    tx_data = 8'h12;
    start = 1'b1;
    t0 = cyc;
    base = mosi_n;
    @(negedge clk);
    tx_data = 8'h34;
    nd = 0; cs_hi = 0; drop = 1'b0; d[0] = -1; d[1] = -1; r[0] = 8'h00; r[1] = 8'h00;
    for (int i = 0; i < 300; i++) begin
      if (drop) start = 1'b0;
      if (done === 1'b1 && nd < 2) begin
        d[nd] = cyc;
        r[nd] = rx_data;
        if (nd == 0) begin
          slave_b0 = s1;
          drop = 1'b1;
        end
        nd++;
      end
      if (nd == 1 && cs === 1'b1) cs_hi++;
      @(negedge clk);
    end
    start = 1'b0;
    n_cmp++;
    if (nd !== 2 || d[1] - d[0] !== exp_gap) begin
      n_bad++; $display("FAIL b2b_done_spacing: got %0d pulses gap %0d expected 2 gap %0d", nd, d[1] - d[0], exp_gap);
    end
    n_cmp++;
    if (cs_hi !== exp_hi) begin n_bad++; $display("FAIL b2b_cs_high: got %0d cycles expected %0d", cs_hi, exp_hi); end
    n_cmp++;
    if (r[0] !== s0 || r[1] !== s1) begin
      n_bad++; $display("FAIL b2b_rx: got %h %h expected %h %h", r[0], r[1], s0, s1);
    end
    n_cmp++;
    if (mosi_log[15:0] !== 16'h1234 || mosi_n - base !== 16) begin
      n_bad++; $display("FAIL b2b_mosi: got %h (%0d bits) expected 1234 (16 bits)", mosi_log[15:0], mosi_n - base);
    end
    n_cmp++;
    if (d[0] !== t0 + 1 + 17 * H0) begin
      n_bad++; $display("FAIL b2b_first_done: got T0+%0d expected T0+%0d", d[0] - t0, 1 + 17 * H0);
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_ignore_start();
    test_random();
    test_half_div1();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
